// File: rtl/pwm_duty_ramp_pkg.sv
// pwm_duty_ramp_pkg: shared states, default widths and the saturating duty step for pwm_duty_ramp.
// PWM_DUTY_RAMP_BREATHE_EN adds the BREATHE_BACK state to the encoding.
package pwm_duty_ramp_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DWELL_W = 8;
`ifdef PWM_DUTY_RAMP_BREATHE_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RAMP, ST_BREATHE_BACK} state_t;
`else
  typedef enum logic {ST_IDLE, ST_RAMP} state_t;
`endif
  // One extra bit keeps the sum and borrow visible, so results clamp at target instead of wrapping.
  function automatic logic [31:0] step_toward(input logic [31:0] duty, input logic [31:0] target,
                                              input logic [31:0] step);
    logic [32:0] up;
    logic [32:0] dn;
    up = {1'b0, duty} + {1'b0, step};
    dn = {1'b0, duty} - {1'b0, step};
    return (step == 32'd0) ? target :
           (duty < target) ? ((up > {1'b0, target}) ? target : up[31:0]) :
           ((dn[32] || dn[31:0] < target) ? target : dn[31:0]);
  endfunction
endpackage

// File: rtl/pwm_period_tracker.sv
// pwm_period_tracker: period counter kept in lockstep with the downstream PWM; tick marks the wrap cycle.
module pwm_period_tracker
  import pwm_duty_ramp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_period,
  output logic             o_tick
);
  logic [WIDTH-1:0] r_pcnt;
  assign o_tick = r_pcnt >= i_period - WIDTH'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pcnt <= '0;
    else r_pcnt <= o_tick ? '0 : r_pcnt + WIDTH'(1);
  end
endmodule

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: walks the PWM duty cycle toward a target, one step per (dwell+1) periods, on period boundaries.
// PWM_DUTY_RAMP_BREATHE_EN enables continuous triangle breathing selected by cfg_breathe.
module pwm_duty_ramp
  import pwm_duty_ramp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DWELL_W = DEF_DWELL_W,
  parameter int RESET_PERIOD = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_period,
  input  logic [WIDTH-1:0]   cfg_target,
  input  logic [WIDTH-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_breathe,
  input  logic               abort,
  output logic [WIDTH-1:0]   period,
  output logic [WIDTH-1:0]   duty_cycle,
  output logic               busy,
  output logic               done
);
  state_t r_state, w_state_nx;
  logic [WIDTH-1:0] r_period, r_duty, r_goal, r_step, w_aim, w_stepped, w_duty_nx;
  logic [DWELL_W-1:0] r_dwell, r_dcnt, w_dcnt_nx;
  logic r_done, w_done_nx, w_tick, w_accept;
  pwm_period_tracker #(.WIDTH(WIDTH)) u_trk (.clk(clk), .rst(rst), .i_period(r_period), .o_tick(w_tick));
  assign w_accept = cfg_valid && r_state == ST_IDLE;
`ifdef PWM_DUTY_RAMP_BREATHE_EN
  logic [WIDTH-1:0] r_start;
  logic r_breathe;
  assign w_aim = (r_state == ST_BREATHE_BACK) ? r_start : r_goal;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start <= '0;
      r_breathe <= 1'b0;
    end else if (w_accept) begin
      r_start <= r_duty;
      r_breathe <= cfg_breathe;
    end
  end
`else
  logic w_unused_breathe;
  assign w_unused_breathe = cfg_breathe;
  assign w_aim = r_goal;
`endif
  assign w_stepped = WIDTH'(step_toward(32'(r_duty), 32'(w_aim), 32'(r_step)));
  always_comb begin
    w_state_nx = r_state;
    w_duty_nx = r_duty;
    w_dcnt_nx = r_dcnt;
    w_done_nx = 1'b0;
    if (r_state == ST_IDLE) begin
      if (cfg_valid) begin
        w_dcnt_nx = '0;
        w_done_nx = cfg_target == r_duty;
        w_state_nx = (cfg_target == r_duty) ? ST_IDLE : ST_RAMP;
      end
    end else if (abort) begin
      w_state_nx = ST_IDLE;
    end else if (w_tick) begin
      w_dcnt_nx = (r_dcnt == r_dwell) ? '0 : r_dcnt + DWELL_W'(1);
      if (r_dcnt == r_dwell) begin
        w_duty_nx = w_stepped;
        if (w_stepped == w_aim) begin
`ifdef PWM_DUTY_RAMP_BREATHE_EN
          w_state_nx = (r_state == ST_BREATHE_BACK) ? ST_RAMP : r_breathe ? ST_BREATHE_BACK : ST_IDLE;
          w_done_nx = r_state == ST_RAMP && !r_breathe;
`else
          w_state_nx = ST_IDLE;
          w_done_nx = 1'b1;
`endif
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_period <= WIDTH'(RESET_PERIOD);
      r_duty <= '0;
      r_dcnt <= '0;
      r_done <= 1'b0;
      r_goal <= '0;
      r_step <= '0;
      r_dwell <= '0;
    end else begin
      r_state <= w_state_nx;
      r_duty <= w_duty_nx;
      r_dcnt <= w_dcnt_nx;
      r_done <= w_done_nx;
      if (w_accept) begin
        r_period <= cfg_period;
        r_goal <= cfg_target;
        r_step <= cfg_step;
        r_dwell <= cfg_dwell;
      end
    end
  end
  assign cfg_ready = r_state == ST_IDLE;
  assign busy = r_state != ST_IDLE;
  assign period = r_period;
  assign duty_cycle = r_duty;
  assign done = r_done;
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb_pwm_duty_ramp: directed bench for pwm_duty_ramp with a reference PWM counter driven from its outputs.
module tb_pwm_duty_ramp;
  logic clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, cfg_breathe = 1'b0, abort = 1'b0;
  logic [15:0] cfg_period = '0, cfg_target = '0, cfg_step = '0;
  logic [7:0] cfg_dwell = '0;
  logic cfg_ready, busy, done;
  logic [15:0] period, duty_cycle;
  logic [15:0] pc = '0, prev_duty = '0;
  int n_asserts = 0, n_fail = 0, lock_err = 0, done_cnt = 0, c = 0;
`ifdef PWM_DUTY_RAMP_BREATHE_EN
  int exp_seq [7] = '{10, 20, 30, 20, 10, 0, 10};
  int exp_done = 7;
`else
  int exp_seq [3] = '{10, 20, 30};
  int exp_done = 8;
`endif

  always #5 clk = ~clk;

  pwm_duty_ramp dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_target(cfg_target), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_breathe(cfg_breathe), .abort(abort),
    .period(period), .duty_cycle(duty_cycle), .busy(busy), .done(done)
  );

  // Reference PWM counter: every duty change must be first seen while it sits at 0.
  always @(posedge clk or posedge rst) pc <= rst ? 16'd0 : (pc >= period - 16'd1) ? 16'd0 : pc + 16'd1;
  always @(negedge clk) begin
    if (!rst && duty_cycle !== prev_duty && pc !== 16'd0) lock_err++;
    if (done === 1'b1) done_cnt++;
    prev_duty = duty_cycle;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] p, input logic [15:0] t, input logic [15:0] s,
                      input logic [7:0] d, input logic b);
    cfg_period = p; cfg_target = t; cfg_step = s; cfg_dwell = d; cfg_breathe = b;
    cfg_valid = 1'b1;
    cycle(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_change(output int cyc);
    logic [15:0] prev;
    prev = duty_cycle;
    cyc = 0;
    do begin
      cycle(1);
      cyc++;
    end while (duty_cycle === prev && cyc < 200);
    chk("wait_change_timeout", 32'(duty_cycle !== prev), 32'd1);
  endtask

  initial begin
    cycle(2);
    chk("rst_period", 32'(period), 32'd1000);
    chk("rst_duty", 32'(duty_cycle), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b0;
    // up-ramp 0 -> 40 by 15, period 10
    send(16'd10, 16'd40, 16'd15, 8'd0, 1'b0);
    chk("acc_period", 32'(period), 32'd10);
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_ready", 32'(cfg_ready), 32'd0);
    wait_change(c);
    chk("up1_cyc", 32'(c), 32'd9);
    chk("up1_duty", 32'(duty_cycle), 32'd15);
    chk("up1_done", 32'(done), 32'd0);
    wait_change(c);
    chk("up2_cyc", 32'(c), 32'd10);
    chk("up2_duty", 32'(duty_cycle), 32'd30);
    wait_change(c);
    chk("up3_cyc", 32'(c), 32'd10);
    chk("up3_duty", 32'(duty_cycle), 32'd40);
    chk("up3_done", 32'(done), 32'd1);
    chk("up3_busy", 32'(busy), 32'd0);
    chk("up3_ready", 32'(cfg_ready), 32'd1);
    cycle(1);
    chk("up_done_pulse", 32'(done), 32'd0);
    chk("up_done_cnt", 32'(done_cnt), 32'd1);
    // step 0 jumps and saturation near full scale
    send(16'd4, 16'hFFF0, 16'd0, 8'd0, 1'b0);
    wait_change(c);
    chk("jump_fff0", 32'(duty_cycle), 32'hFFF0);
    chk("jump_fff0_done", 32'(done), 32'd1);
    send(16'd4, 16'hFFFF, 16'h0020, 8'd0, 1'b0);
    wait_change(c);
    chk("sat_ffff", 32'(duty_cycle), 32'hFFFF);
    chk("sat_done", 32'(done), 32'd1);
    send(16'd4, 16'd500, 16'd0, 8'd0, 1'b0);
    wait_change(c);
    chk("jump_500", 32'(duty_cycle), 32'd500);
    send(16'd4, 16'd500, 16'd7, 8'd0, 1'b0);
    chk("eq_done", 32'(done), 32'd1);
    chk("eq_busy", 32'(busy), 32'd0);
    chk("eq_ready", 32'(cfg_ready), 32'd1);
    // dwell 2, period 8
    send(16'd8, 16'd530, 16'd10, 8'd2, 1'b0);
    wait_change(c);
    chk("dw1_duty", 32'(duty_cycle), 32'd510);
    wait_change(c);
    chk("dw2_cyc", 32'(c), 32'd24);
    chk("dw2_duty", 32'(duty_cycle), 32'd520);
    wait_change(c);
    chk("dw3_cyc", 32'(c), 32'd24);
    chk("dw3_duty", 32'(duty_cycle), 32'd530);
    chk("dw3_done", 32'(done), 32'd1);
    // abort on a step tick; cfg_valid during RAMP ignored
    send(16'd10, 16'd600, 16'd10, 8'd0, 1'b0);
    wait_change(c);
    chk("ab1_duty", 32'(duty_cycle), 32'd540);
    send(16'd20, 16'd0, 16'd1, 8'd0, 1'b0);
    chk("ramp_cfg_ign_busy", 32'(busy), 32'd1);
    chk("ramp_cfg_ign_period", 32'(period), 32'd10);
    cycle(8);
    abort = 1'b1;
    cycle(1);
    abort = 1'b0;
    chk("ab_duty", 32'(duty_cycle), 32'd540);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_ready", 32'(cfg_ready), 32'd1);
    chk("ab_done", 32'(done), 32'd0);
    cycle(15);
    chk("ab_hold", 32'(duty_cycle), 32'd540);
    chk("ab_done_cnt", 32'(done_cnt), 32'd6);
    // breathe stimulus from 0
    send(16'd4, 16'd0, 16'd0, 8'd0, 1'b0);
    wait_change(c);
    chk("zero_duty", 32'(duty_cycle), 32'd0);
    send(16'd4, 16'd30, 16'd10, 8'd0, 1'b1);
    foreach (exp_seq[i]) begin
      wait_change(c);
      chk("br_duty", 32'(duty_cycle), 32'(exp_seq[i]));
      chk("br_cyc", 32'(c), (i == 0) ? 32'(c) : 32'd4);
    end
`ifdef PWM_DUTY_RAMP_BREATHE_EN
    chk("br_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    cycle(1);
    abort = 1'b0;
    chk("br_ab_busy", 32'(busy), 32'd0);
    chk("br_ab_duty", 32'(duty_cycle), 32'd10);
`else
    chk("br_off_done", 32'(done), 32'd1);
    chk("br_off_busy", 32'(busy), 32'd0);
`endif
    // asynchronous reset mid-ramp
    send(16'd6, 16'd100, 16'd10, 8'd0, 1'b0);
    wait_change(c);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_period", 32'(period), 32'd1000);
    chk("arst_duty", 32'(duty_cycle), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(cfg_ready), 32'd1);
    cycle(2);
    rst = 1'b0;
    cycle(3);
    chk("post_rst_period", 32'(period), 32'd1000);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("lockstep_errors", 32'(lock_err), 32'd0);
    chk("done_total", 32'(done_cnt), 32'(exp_done));
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
